// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch control FSM.
// Sequences the PC counter (load/run) and instruction-memory requests, tracks
// branch redirects that arrive while a fetch is outstanding, and flags a
// sticky timeout when memory fails to answer within MAX_WAIT cycles.
//
// Memory handshake: imem_req acts as "valid". While imem_req=1, imem_addr is
// stable and equal to pc, and the request is held until the cycle that
// imem_ack ("ready") is high. A transfer completes on a rising edge where
// both are high. imem_ack is ignored whenever imem_req=0.
module fetch_sequencer #(
   parameter int                    ADDR_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
   parameter int                    MAX_WAIT   = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  stall,
   input  logic [ADDR_WIDTH-1:0] pc,
   input  logic                  branch_valid,
   input  logic [ADDR_WIDTH-1:0] branch_target,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_ack,
   output logic                  load_pc,
   output logic                  run_pc,
   output logic [ADDR_WIDTH-1:0] pc_load_val,
   output logic                  instr_valid,
   output logic [ADDR_WIDTH-1:0] instr_addr,
   output logic                  timeout,
   output logic [2:0]            dbg_state
);

   typedef enum logic [2:0] {
      S_INIT  = 3'd0,
      S_IDLE  = 3'd1,
      S_FETCH = 3'd2,
      S_HOLD  = 3'd3,
      S_ERROR = 3'd4
   } state_t;

   // MAX_WAIT is limited to 1..255, so an 8-bit wait counter always suffices.
   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

   state_t                  state, state_nxt;
   logic [7:0]              wait_cnt, wait_nxt, wait_inc;
   logic                    pend_valid, pend_valid_nxt;
   logic [ADDR_WIDTH-1:0]   pend_addr, pend_addr_nxt;
   logic                    ack_fetch;
   logic                    timeout_set;

   assign wait_inc  = wait_cnt + 8'd1;
   assign imem_addr = imem_req ? pc : '0;
   assign dbg_state = state;

   // State, wait counter, pending redirect and registered notices.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_INIT;
         wait_cnt    <= 8'd0;
         pend_valid  <= 1'b0;
         pend_addr   <= '0;
         instr_valid <= 1'b0;
         instr_addr  <= '0;
         timeout     <= 1'b0;
      end else begin
         state       <= state_nxt;
         wait_cnt    <= wait_nxt;
         pend_valid  <= pend_valid_nxt;
         pend_addr   <= pend_addr_nxt;
         instr_valid <= ack_fetch;
         instr_addr  <= ack_fetch ? pc : '0;
         timeout     <= timeout | timeout_set;
      end
   end

   // Next-state and combinational counter/memory controls. Outputs are forced
   // low while rst is asserted so that reset clears them immediately even
   // though INIT itself drives load_pc.
   always_comb begin
      state_nxt      = state;
      wait_nxt       = 8'd0;
      pend_valid_nxt = pend_valid;
      pend_addr_nxt  = pend_addr;
      imem_req       = 1'b0;
      load_pc        = 1'b0;
      run_pc         = 1'b0;
      pc_load_val    = '0;
      ack_fetch      = 1'b0;
      timeout_set    = 1'b0;

      if (rst) begin
         case (state)
            S_INIT: begin
               // One-cycle PC preset; redirects are ignored here.
               load_pc     = 1'b1;
               pc_load_val = RESET_ADDR;
               state_nxt   = S_IDLE;
            end

            S_IDLE: begin
               if (branch_valid) begin
                  load_pc     = 1'b1;
                  pc_load_val = branch_target;
               end
               if (enable) begin
                  state_nxt = S_FETCH;
               end
            end

            S_FETCH: begin
               // The request stays up even if enable drops; the outstanding
               // fetch must complete (or time out) first.
               imem_req = 1'b1;
               if (imem_ack) begin
                  ack_fetch      = 1'b1;
                  pend_valid_nxt = 1'b0;
                  pend_addr_nxt  = '0;
                  // The freshest redirect wins; otherwise just advance the PC.
                  if (branch_valid) begin
                     load_pc     = 1'b1;
                     pc_load_val = branch_target;
                  end else if (pend_valid) begin
                     load_pc     = 1'b1;
                     pc_load_val = pend_addr;
                  end else begin
                     run_pc = 1'b1;
                  end
                  if (!enable) begin
                     state_nxt = S_IDLE;
                  end else if (stall) begin
                     state_nxt = S_HOLD;
                  end else begin
                     state_nxt = S_FETCH;
                  end
               end else begin
                  // Remember the redirect until the fetch completes.
                  if (branch_valid) begin
                     pend_valid_nxt = 1'b1;
                     pend_addr_nxt  = branch_target;
                  end
                  if (wait_inc == MAX_WAIT_C) begin
                     state_nxt      = S_ERROR;
                     timeout_set    = 1'b1;
                     pend_valid_nxt = 1'b0;
                     pend_addr_nxt  = '0;
                  end else begin
                     wait_nxt = wait_inc;
                  end
               end
            end

            S_HOLD: begin
               if (branch_valid) begin
                  load_pc     = 1'b1;
                  pc_load_val = branch_target;
               end
               if (!enable) begin
                  state_nxt = S_IDLE;
               end else if (!stall) begin
                  state_nxt = S_FETCH;
               end
            end

            S_ERROR: begin
               // Dead until reset; timeout stays latched.
               state_nxt = S_ERROR;
            end

            default: begin
               state_nxt = S_INIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed bench for fetch_sequencer with an expected-
// address queue for completed fetches.
module tb_fetch_sequencer;

   localparam int         AW     = 8;
   localparam logic [7:0] R_ADDR = 8'h10;
   localparam int         MW     = 4;

   localparam int ST_INIT  = 0;
   localparam int ST_IDLE  = 1;
   localparam int ST_FETCH = 2;
   localparam int ST_HOLD  = 3;
   localparam int ST_ERROR = 4;

   logic          clk;
   logic          rst;
   logic          enable;
   logic          stall;
   logic [AW-1:0] pc;
   logic          branch_valid;
   logic [AW-1:0] branch_target;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack;
   logic          load_pc;
   logic          run_pc;
   logic [AW-1:0] pc_load_val;
   logic          instr_valid;
   logic [AW-1:0] instr_addr;
   logic          timeout;
   logic [2:0]    dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   logic [AW-1:0] exp_q[$];

   fetch_sequencer #(
      .ADDR_WIDTH (AW),
      .RESET_ADDR (R_ADDR),
      .MAX_WAIT   (MW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .stall         (stall),
      .pc            (pc),
      .branch_valid  (branch_valid),
      .branch_target (branch_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .load_pc       (load_pc),
      .run_pc        (run_pc),
      .pc_load_val   (pc_load_val),
      .instr_valid   (instr_valid),
      .instr_addr    (instr_addr),
      .timeout       (timeout),
      .dbg_state     (dbg_state)
   );

   // Clock: rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge; inputs change here.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every completed fetch must report the address queued at ack;
   // load_pc and run_pc must never overlap.
   always @(negedge clk) begin
      check("load_run_excl", 32'(load_pc & run_pc), 32'h0);
      if (instr_valid) begin
         if (exp_q.size() == 0) begin
            check("spurious_instr_valid", 32'(instr_valid), 32'h0);
         end else begin
            check("instr_addr", 32'(instr_addr), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      rst           = 1'b0;
      enable        = 1'b0;
      stall         = 1'b0;
      pc            = '0;
      branch_valid  = 1'b0;
      branch_target = '0;
      imem_ack      = 1'b0;

      // Reset state
      #2;
      check("rst_state",     32'(dbg_state),   ST_INIT);
      check("rst_load_pc",   32'(load_pc),     32'h0);
      check("rst_imem_req",  32'(imem_req),    32'h0);
      check("rst_imem_addr", 32'(imem_addr),   32'h0);
      check("rst_iv",        32'(instr_valid), 32'h0);
      check("rst_iaddr",     32'(instr_addr),  32'h0);
      check("rst_timeout",   32'(timeout),     32'h0);
      cyc();
      cyc();

      // Reset release: one INIT cycle with the reset address preset
      rst = 1'b1;
      pc  = 8'h10;
      @(negedge clk);
      check("init_state",   32'(dbg_state),   ST_INIT);
      check("init_load_pc", 32'(load_pc),     32'h1);
      check("init_val",     32'(pc_load_val), 32'h10);
      check("init_run_pc",  32'(run_pc),      32'h0);
      cyc();
      @(negedge clk);
      check("idle_state",   32'(dbg_state), ST_IDLE);
      check("idle_load_pc", 32'(load_pc),   32'h0);
      check("idle_req",     32'(imem_req),  32'h0);
      check("idle_addr",    32'(imem_addr), 32'h0);

      // Branch in IDLE loads immediately
      cyc();
      branch_valid  = 1'b1;
      branch_target = 8'h33;
      @(negedge clk);
      check("idle_br_load", 32'(load_pc),     32'h1);
      check("idle_br_val",  32'(pc_load_val), 32'h33);
      check("idle_br_stay", 32'(dbg_state),   ST_IDLE);

      // Fetch at 0x10, ack on the third FETCH cycle
      cyc();
      branch_valid = 1'b0;
      enable       = 1'b1;
      cyc();
      @(negedge clk);
      check("f1_state", 32'(dbg_state), ST_FETCH);
      check("f1_req",   32'(imem_req),  32'h1);
      check("f1_addr",  32'(imem_addr), 32'h10);
      check("f1_run",   32'(run_pc),    32'h0);
      cyc();
      cyc();
      imem_ack = 1'b1;
      exp_q.push_back(8'h10);
      @(negedge clk);
      check("ack_run",  32'(run_pc),  32'h1);
      check("ack_load", 32'(load_pc), 32'h0);
      cyc();
      imem_ack = 1'b0;
      pc       = 8'h11;
      @(negedge clk);
      check("post_ack_iv",    32'(instr_valid), 32'h1);
      check("post_ack_state", 32'(dbg_state),   ST_FETCH);
      check("post_ack_run",   32'(run_pc),      32'h0);

      // Branch during wait, ack two cycles later
      branch_valid  = 1'b1;
      branch_target = 8'h40;
      #1;
      check("wait_br_noload", 32'(load_pc), 32'h0);
      cyc();
      branch_valid = 1'b0;
      cyc();
      imem_ack = 1'b1;
      exp_q.push_back(8'h11);
      @(negedge clk);
      check("pend_load", 32'(load_pc),     32'h1);
      check("pend_val",  32'(pc_load_val), 32'h40);
      check("pend_run",  32'(run_pc),      32'h0);

      // Pending 0x20, then 0x40 arrives with ack: newest target wins
      cyc();
      imem_ack      = 1'b0;
      pc            = 8'h12;
      branch_valid  = 1'b1;
      branch_target = 8'h20;
      cyc();
      branch_target = 8'h40;
      imem_ack      = 1'b1;
      exp_q.push_back(8'h12);
      @(negedge clk);
      check("newest_load", 32'(load_pc),     32'h1);
      check("newest_val",  32'(pc_load_val), 32'h40);
      check("newest_run",  32'(run_pc),      32'h0);

      // Pending cleared: plain ack runs; stall at ack goes to HOLD
      cyc();
      branch_valid = 1'b0;
      pc           = 8'h13;
      stall        = 1'b1;
      exp_q.push_back(8'h13);
      @(negedge clk);
      check("clr_run",  32'(run_pc),  32'h1);
      check("clr_load", 32'(load_pc), 32'h0);
      cyc();
      imem_ack = 1'b0;
      @(negedge clk);
      check("hold_state", 32'(dbg_state), ST_HOLD);
      check("hold_req",   32'(imem_req),  32'h0);
      check("hold_addr",  32'(imem_addr), 32'h0);
      cyc();
      branch_valid  = 1'b1;
      branch_target = 8'h55;
      @(negedge clk);
      check("hold_br_load", 32'(load_pc),     32'h1);
      check("hold_br_val",  32'(pc_load_val), 32'h55);
      check("hold_br_stay", 32'(dbg_state),   ST_HOLD);
      cyc();
      branch_valid = 1'b0;
      stall        = 1'b0;
      cyc();
      @(negedge clk);
      check("unhold_state", 32'(dbg_state), ST_FETCH);
      check("unhold_req",   32'(imem_req),  32'h1);

      // enable drops mid-fetch: request held until ack, then IDLE
      enable = 1'b0;
      pc     = 8'h14;
      cyc();
      @(negedge clk);
      check("en_drop_req",   32'(imem_req),  32'h1);
      check("en_drop_state", 32'(dbg_state), ST_FETCH);
      imem_ack = 1'b1;
      exp_q.push_back(8'h14);
      cyc();
      imem_ack = 1'b0;
      @(negedge clk);
      check("en_drop_idle", 32'(dbg_state), ST_IDLE);

      // Ack on the MAX_WAIT-th FETCH cycle beats the timeout
      enable = 1'b1;
      pc     = 8'h15;
      cyc();
      cyc();
      cyc();
      cyc();
      imem_ack = 1'b1;
      exp_q.push_back(8'h15);
      @(negedge clk);
      check("edge_ack_state", 32'(dbg_state), ST_FETCH);
      check("edge_ack_run",   32'(run_pc),    32'h1);
      cyc();
      imem_ack = 1'b0;
      @(negedge clk);
      check("edge_ack_fetch", 32'(dbg_state), ST_FETCH);
      check("edge_ack_to",    32'(timeout),   32'h0);

      // No ack for MAX_WAIT cycles -> ERROR, sticky timeout
      cyc();
      cyc();
      cyc();
      @(negedge clk);
      check("to_c4_state", 32'(dbg_state), ST_FETCH);
      check("to_c4_flag",  32'(timeout),   32'h0);
      cyc();
      branch_valid  = 1'b1;
      branch_target = 8'h77;
      imem_ack      = 1'b1;
      @(negedge clk);
      check("err_state", 32'(dbg_state), ST_ERROR);
      check("err_to",    32'(timeout),   32'h1);
      check("err_req",   32'(imem_req),  32'h0);
      check("err_load",  32'(load_pc),   32'h0);
      check("err_run",   32'(run_pc),    32'h0);
      cyc();
      branch_valid = 1'b0;
      imem_ack     = 1'b0;
      cyc();
      @(negedge clk);
      check("err_sticky", 32'(timeout),   32'h1);
      check("err_stay",   32'(dbg_state), ST_ERROR);

      // Reset pulse clears timeout and returns to INIT
      cyc();
      rst = 1'b0;
      #1;
      check("rp_to",    32'(timeout),   32'h0);
      check("rp_state", 32'(dbg_state), ST_INIT);
      check("rp_load",  32'(load_pc),   32'h0);
      check("rp_req",   32'(imem_req),  32'h0);
      cyc();
      rst = 1'b1;
      pc  = 8'h16;
      @(negedge clk);
      check("rp_init_load", 32'(load_pc),     32'h1);
      check("rp_init_val",  32'(pc_load_val), 32'h10);
      cyc();
      cyc();
      @(negedge clk);
      check("rp_fetch_req", 32'(imem_req), 32'h1);

      // Reset mid-fetch with ack pending: no completion notice
      #2;
      imem_ack = 1'b1;
      rst      = 1'b0;
      #1;
      check("mid_rst_req",   32'(imem_req),  32'h0);
      check("mid_rst_state", 32'(dbg_state), ST_INIT);
      cyc();
      @(negedge clk);
      check("mid_rst_iv", 32'(instr_valid), 32'h0);
      imem_ack = 1'b0;
      enable   = 1'b0;
      rst      = 1'b1;
      cyc();
      cyc();
      @(negedge clk);
      check("mid_rst_iv2", 32'(instr_valid), 32'h0);
      check("exp_q_empty", 32'(exp_q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
